// File: rtl/ascii_pkg.sv
// Shared character constants and parser state encoding for ASCII stream parsers.
// Pure declarations; no logic, no latency, no flow control.
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SIGN  = 3'd1,
        MUL   = 3'd2,
        DIGIT = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/ascii_char_class.sv
// Classifies one ASCII byte as digit / sign / field terminator and extracts the digit value.
// Purely combinational, zero latency; no flow control.
// Backpressure: none, the caller qualifies the result with its own handshake.
module ascii_char_class
    import ascii_pkg::*;
(
    input  logic [7:0] ascii_in,
    output logic       is_digit,
    output logic       is_sign,
    output logic       is_minus,
    output logic       is_term,
    output logic [3:0] digit
);

    assign is_digit = (ascii_in >= ASCII_ZERO) && (ascii_in <= ASCII_NINE);
    assign is_minus = (ascii_in == ASCII_MINUS);
    assign is_sign  = is_minus || (ascii_in == ASCII_PLUS);
    assign is_term  = (ascii_in == ASCII_CR) || (ascii_in == ASCII_LF) || (ascii_in == ASCII_COMMA);
    // Only meaningful when is_digit; the low nibble of '0'..'9' is the value.
    assign digit    = ascii_in[3:0];

endmodule

// File: rtl/ascii_to_bin.sv
// Parses signed decimal fields from an ASCII byte stream into a two's-complement word.
// Latency: bin_valid/err pulse one cycle after the terminator handshake.
// Backpressure: ascii_ready drops for the single multiply cycle after each digit.
module ascii_to_bin
    import ascii_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       ascii_in,
    input  logic             ascii_valid,
    output logic             ascii_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             is_negative,
    output logic             err
);

    localparam int ACC_W = WIDTH + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [ACC_W-1:0] LIM_NEG = ACC_W'(1) << (WIDTH - 1);
    localparam logic [ACC_W-1:0] LIM_POS = LIM_NEG - ACC_W'(1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [3:0]         dig_q, dig_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic               neg_q, neg_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;

    logic               is_digit, is_sign, is_minus, is_term;
    logic [3:0]         digit;
    logic               accept;
    logic [ACC_W-1:0]   acc_mul;
    logic [ACC_W-1:0]   limit;
    logic [WIDTH-1:0]   acc_neg;

    ascii_char_class u_class (
        .ascii_in (ascii_in),
        .is_digit (is_digit),
        .is_sign  (is_sign),
        .is_minus (is_minus),
        .is_term  (is_term),
        .digit    (digit)
    );

    assign ascii_ready = (state_q != MUL);
    assign accept      = ascii_valid && ascii_ready;
    assign acc_mul     = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, dig_q};
    assign limit       = sign_q ? LIM_NEG : LIM_POS;
    // Low WIDTH bits of the negation depend only on the low WIDTH bits of acc.
    assign acc_neg     = ~acc_q[WIDTH-1:0] + WIDTH'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        dig_d   = dig_q;
        bin_d   = bin_q;
        neg_d   = neg_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (is_term) begin
                    state_d = IDLE;
                end else if (is_sign) begin
                    state_d = SIGN;
                    sign_d  = is_minus;
                end else if (is_digit) begin
                    state_d = MUL;
                    dig_d   = digit;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ERR;
                end
            end
            SIGN: if (accept) begin
                if (is_digit) begin
                    state_d = MUL;
                    dig_d   = digit;
                    cnt_d   = CNT_W'(1);
                end else if (is_term) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ERR;
                end
            end
            MUL: begin
                acc_d   = acc_mul;
                state_d = (acc_mul > limit) ? ERR : DIGIT;
            end
            DIGIT: if (accept) begin
                if (is_digit) begin
                    if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                        state_d = MUL;
                        dig_d   = digit;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = ERR;
                    end
                end else if (is_term) begin
                    state_d = IDLE;
                    bin_d   = sign_q ? acc_neg : acc_q[WIDTH-1:0];
                    neg_d   = sign_q && (acc_q != '0);
                    vld_d   = 1'b1;
                end else begin
                    state_d = ERR;
                end
            end
            ERR: if (accept && is_term) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            acc_d  = '0;
            cnt_d  = '0;
            sign_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            dig_q   <= '0;
            bin_q   <= '0;
            neg_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            dig_q   <= dig_d;
            bin_q   <= bin_d;
            neg_q   <= neg_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign bin_out     = bin_q;
    assign is_negative = neg_q;
    assign bin_valid   = vld_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ascii_to_bin.sv
// Directed bench for ascii_to_bin: signed fields, overflow, illegal characters, async reset.
module tb_ascii_to_bin;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  ascii_in = 8'h00;
    logic        ascii_valid = 1'b0;
    logic        ascii_ready;
    logic [11:0] bin_out;
    logic        bin_valid;
    logic        is_negative;
    logic        err;

    int checks = 0, failures = 0;
    int nvld = 0, nerr = 0, nboth = 0, rdy_bad = 0;
    int v0, e0;

    ascii_to_bin #(.WIDTH(12), .MAX_DIGITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .ascii_in    (ascii_in),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .bin_out     (bin_out),
        .bin_valid   (bin_valid),
        .is_negative (is_negative),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bin_valid === 1'b1) nvld++;
        if (err === 1'b1) nerr++;
        if (bin_valid === 1'b1 && err === 1'b1) nboth++;
    end

    // Streams a string with valid held high; returns at the negedge after the last handshake.
    task automatic send_str(input string s, input bit chk_rdy);
        for (int i = 0; i < s.len(); i++) begin
            int n;
            logic [7:0] c;
            n = 0;
            c = s[i];
            ascii_in = c;
            ascii_valid = 1'b1;
            while (ascii_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                checks++; failures++;
                $display("FAIL send_timeout char=%h ready=%b required=1", c, ascii_ready);
            end
            @(posedge clk);
            @(negedge clk);
            if (chk_rdy && c >= 8'h30 && c <= 8'h39 && ascii_ready !== 1'b0) rdy_bad++;
        end
        ascii_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++; if (bin_out !== 12'h000 || is_negative !== 1'b0) begin failures++; $display("FAIL reset_out bin=%h neg=%b required bin=000 neg=0", bin_out, is_negative); end
        checks++; if (bin_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_pulses vld=%b err=%b required 0 0", bin_valid, err); end
        checks++; if (ascii_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b required=1", ascii_ready); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        v0 = nvld; e0 = nerr; rdy_bad = 0;
        send_str("1234\r", 1'b1);
        checks++; if (bin_valid !== 1'b1) begin failures++; $display("FAIL basic_vld got=%b required=1", bin_valid); end
        checks++; if (bin_out !== 12'h4D2 || is_negative !== 1'b0) begin failures++; $display("FAIL basic_val bin=%h neg=%b required 4d2 0", bin_out, is_negative); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b required=0", err); end
        @(negedge clk);
        checks++; if (bin_valid !== 1'b0) begin failures++; $display("FAIL basic_vld_width got=%b required=0", bin_valid); end
        settle();
        checks++; if (nvld - v0 != 1 || nerr != e0) begin failures++; $display("FAIL basic_counts vld=%0d err=%0d required 1 0", nvld - v0, nerr - e0); end
        checks++; if (rdy_bad != 0) begin failures++; $display("FAIL basic_ready_low missed=%0d required=0", rdy_bad); end
    endtask

    task automatic test_signed();
        v0 = nvld;
        send_str("-2048\n", 1'b1);
        checks++; if (bin_valid !== 1'b1 || bin_out !== 12'h800 || is_negative !== 1'b1) begin failures++; $display("FAIL min_neg vld=%b bin=%h neg=%b required 1 800 1", bin_valid, bin_out, is_negative); end
        send_str("+2047,", 1'b1);
        checks++; if (bin_valid !== 1'b1 || bin_out !== 12'h7FF || is_negative !== 1'b0) begin failures++; $display("FAIL max_pos vld=%b bin=%h neg=%b required 1 7ff 0", bin_valid, bin_out, is_negative); end
        settle();
        checks++; if (nvld - v0 != 2) begin failures++; $display("FAIL signed_pulses got=%0d required=2", nvld - v0); end
    endtask

    task automatic test_overflow();
        send_str("5\r", 1'b1);
        checks++; if (bin_out !== 12'h005) begin failures++; $display("FAIL five bin=%h required=005", bin_out); end
        settle();
        v0 = nvld; e0 = nerr;
        send_str("2048\r", 1'b1);
        checks++; if (err !== 1'b1 || bin_valid !== 1'b0) begin failures++; $display("FAIL ovf_pulse err=%b vld=%b required 1 0", err, bin_valid); end
        checks++; if (bin_out !== 12'h005 || is_negative !== 1'b0) begin failures++; $display("FAIL ovf_hold bin=%h neg=%b required 005 0", bin_out, is_negative); end
        send_str("12345\r", 1'b0);
        checks++; if (err !== 1'b1 || bin_out !== 12'h005) begin failures++; $display("FAIL too_many err=%b bin=%h required 1 005", err, bin_out); end
        settle();
        checks++; if (nvld != v0 || nerr - e0 != 2) begin failures++; $display("FAIL ovf_counts vld=%0d err=%0d required 0 2", nvld - v0, nerr - e0); end
    endtask

    task automatic test_illegal();
        send_str("12a4\r", 1'b0);
        checks++; if (err !== 1'b1 || bin_valid !== 1'b0) begin failures++; $display("FAIL illegal_err err=%b vld=%b required 1 0", err, bin_valid); end
        send_str("7,", 1'b1);
        checks++; if (bin_valid !== 1'b1 || bin_out !== 12'h007) begin failures++; $display("FAIL after_err vld=%b bin=%h required 1 007", bin_valid, bin_out); end
        settle();
        v0 = nvld; e0 = nerr;
        send_str("\r\n", 1'b1);
        settle();
        checks++; if (nvld != v0 || nerr != e0) begin failures++; $display("FAIL empty_field vld=%0d err=%0d required 0 0", nvld - v0, nerr - e0); end
        send_str("-\r", 1'b0);
        checks++; if (err !== 1'b1 || bin_out !== 12'h007) begin failures++; $display("FAIL sign_only err=%b bin=%h required 1 007", err, bin_out); end
    endtask

    task automatic test_neg_zero();
        send_str("-0\r", 1'b1);
        checks++; if (bin_valid !== 1'b1 || bin_out !== 12'h000 || is_negative !== 1'b0) begin failures++; $display("FAIL neg_zero vld=%b bin=%h neg=%b required 1 000 0", bin_valid, bin_out, is_negative); end
    endtask

    task automatic test_reset_mid();
        send_str("9\r", 1'b1);
        send_str("-12", 1'b1);
        #2 reset = 1'b1;
        #1;
        checks++; if (bin_out !== 12'h000 || is_negative !== 1'b0 || bin_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mid_reset bin=%h neg=%b vld=%b err=%b required 000 0 0 0", bin_out, is_negative, bin_valid, err); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_str("5\r", 1'b1);
        checks++; if (bin_valid !== 1'b1 || bin_out !== 12'h005 || is_negative !== 1'b0) begin failures++; $display("FAIL post_reset vld=%b bin=%h neg=%b required 1 005 0", bin_valid, bin_out, is_negative); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_illegal();
        test_neg_zero();
        test_reset_mid();
        settle();
        checks++; if (nboth != 0) begin failures++; $display("FAIL vld_err_overlap got=%0d required=0", nboth); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
